// File: rtl/ssem_seq_pkg.sv
// Shared types for the SSEM control sequencer: opcodes, FSM states, bus endpoints.
package ssem_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LDA   = 3'd1,
    OP_LDB   = 3'd2,
    OP_ADD   = 3'd3,
    OP_SUB   = 3'd4,
    OP_STA   = 3'd5,
    OP_MOVAB = 3'd6,
    OP_ILL   = 3'd7
  } op_e;

  // SETUP/STROBE/HOLD live inside the transfer engine; DONE is folded into IDLE.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_LATCH,
    ST_XFER
  } state_e;

  typedef enum logic [1:0] {
    SRC_EXT,
    SRC_A,
    SRC_B,
    SRC_ALU
  } src_e;

  typedef enum logic [1:0] {
    DST_A,
    DST_B,
    DST_EXT
  } dst_e;

  localparam int XFER_CYCLES    = 3;
  localparam int XFER_STROBE_AT = 2;

  function automatic logic [3:0] src_oh(src_e s);
    return 4'b0001 << s;
  endfunction

  function automatic logic [2:0] dst_oh(dst_e d);
    return 3'b001 << d;
  endfunction

endpackage

// File: rtl/ssem_bus_xfer.sv
// Three-cycle bus transfer engine: source OE for SETUP/STROBE/HOLD, destination LE
// in STROBE only, so the driver is always still on the bus when the sink latches.
module ssem_bus_xfer
  import ssem_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_start,
  input  src_e       i_src,
  input  dst_e       i_dst,
  output logic [3:0] o_oe,
  output logic [2:0] o_le,
  output logic       o_last
);

  localparam logic [1:0] LAST   = 2'(XFER_CYCLES);
  localparam logic [1:0] STROBE = 2'(XFER_STROBE_AT);

  logic [1:0] r_cnt, w_cnt_nxt;
  src_e       r_src, w_src;
  dst_e       r_dst, w_dst;

  always_comb begin
    w_cnt_nxt = '0;
    if (i_start)
      w_cnt_nxt = 2'd1;
    else if (r_cnt != '0 && r_cnt != LAST)
      w_cnt_nxt = r_cnt + 2'd1;
    w_src = i_start ? i_src : r_src;
    w_dst = i_start ? i_dst : r_dst;
  end

  // Strobes are computed from the next count so they appear registered in-phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_src <= SRC_EXT;
      r_dst <= DST_A;
      o_oe  <= '0;
      o_le  <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_src <= w_src;
      r_dst <= w_dst;
      o_oe  <= (w_cnt_nxt != '0)    ? src_oh(w_src) : '0;
      o_le  <= (w_cnt_nxt == STROBE) ? dst_oh(w_dst) : '0;
    end
  end

  assign o_last = (r_cnt == LAST);

endmodule

// File: rtl/ssem_sequencer.sv
// SSEM micro-sequencer: decodes one command at a time into registered datapath strobes.
// Optional accumulator flags are built when SSEM_SEQ_FLAGS_EN is defined.
module ssem_sequencer
  import ssem_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1  // legal range 1..15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_op,
  output logic        cmd_ready,
  output logic        done,
  output logic        cmd_err,
  output logic        load_A,
  output logic        load_B,
  output logic        a_to_bus,
  output logic        b_to_bus,
  output logic        alu_to_bus,
  output logic        alu_sub,
  output logic        alu_latch,
  output logic        ext_to_bus,
  output logic        ext_capture
`ifdef SSEM_SEQ_FLAGS_EN
  ,
  input  logic [31:0] bus_in,
  output logic        acc_zero,
  output logic        acc_neg
`endif
);

  state_e     r_state, w_state_nxt;
  logic [3:0] r_settle, w_settle_nxt;
  logic       w_accept, w_start, w_sub_nxt, w_done_nxt, w_err_nxt, w_xfer_last;
  src_e       w_src;
  dst_e       w_dst;
  logic [3:0] w_oe;
  logic [2:0] w_le;
  op_e        w_op;

  assign w_op     = op_e'(cmd_op);
  assign w_accept = cmd_valid && cmd_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle;
    w_start      = 1'b0;
    w_src        = SRC_EXT;
    w_dst        = DST_A;
    w_sub_nxt    = alu_sub;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_sub_nxt = 1'b0;
        if (w_accept) begin
          case (w_op)
            OP_LDA:   begin w_start = 1'b1; w_src = SRC_EXT; w_dst = DST_A;   w_state_nxt = ST_XFER; end
            OP_LDB:   begin w_start = 1'b1; w_src = SRC_EXT; w_dst = DST_B;   w_state_nxt = ST_XFER; end
            OP_STA:   begin w_start = 1'b1; w_src = SRC_A;   w_dst = DST_EXT; w_state_nxt = ST_XFER; end
            OP_MOVAB: begin w_start = 1'b1; w_src = SRC_A;   w_dst = DST_B;   w_state_nxt = ST_XFER; end
            OP_ADD, OP_SUB: begin
              w_state_nxt  = ST_SETTLE;
              w_settle_nxt = 4'd1;
              w_sub_nxt    = (w_op == OP_SUB);
            end
            default: begin
              w_done_nxt = 1'b1;
              w_err_nxt  = (w_op == OP_ILL);
            end
          endcase
        end
      end
      ST_SETTLE: begin
        if (r_settle == 4'(SETTLE_CYCLES))
          w_state_nxt = ST_LATCH;
        else
          w_settle_nxt = r_settle + 4'd1;
      end
      // The result transfer is launched here so SETUP follows the latch pulse directly.
      ST_LATCH: begin
        w_start     = 1'b1;
        w_src       = SRC_ALU;
        w_dst       = DST_A;
        w_state_nxt = ST_XFER;
      end
      ST_XFER: begin
        if (w_xfer_last) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
          w_sub_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_settle  <= '0;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      cmd_err   <= 1'b0;
      alu_sub   <= 1'b0;
      alu_latch <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_settle  <= w_settle_nxt;
      cmd_ready <= (w_state_nxt == ST_IDLE);
      done      <= w_done_nxt;
      cmd_err   <= w_err_nxt;
      alu_sub   <= w_sub_nxt;
      alu_latch <= (w_state_nxt == ST_LATCH);
    end
  end

  ssem_bus_xfer u_xfer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_start (w_start),
    .i_src   (w_src),
    .i_dst   (w_dst),
    .o_oe    (w_oe),
    .o_le    (w_le),
    .o_last  (w_xfer_last)
  );

  assign ext_to_bus  = w_oe[SRC_EXT];
  assign a_to_bus    = w_oe[SRC_A];
  assign b_to_bus    = w_oe[SRC_B];
  assign alu_to_bus  = w_oe[SRC_ALU];
  assign load_A      = w_le[DST_A];
  assign load_B      = w_le[DST_B];
  assign ext_capture = w_le[DST_EXT];

`ifdef SSEM_SEQ_FLAGS_EN
  // load_A is high exactly in the STROBE cycle of any transfer into A.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_zero <= 1'b0;
      acc_neg  <= 1'b0;
    end else if (load_A) begin
      acc_zero <= (bus_in == 32'h0);
      acc_neg  <= bus_in[31];
    end
  end
`endif

endmodule

// File: tb/tb_ssem_sequencer.sv
// Bench for ssem_sequencer: two instances (SETTLE_CYCLES 1 and 4) against a cycle schedule model.
module tb_ssem_sequencer;

  typedef struct packed {
    logic ready, done, err, ld_a, ld_b, a_bus, b_bus, alu_bus, sub, latch, ext_bus, ext_cap;
  } vec_t;

  localparam vec_t IDLE_V = vec_t'(12'h800);
  localparam int B_RDY = 11, B_DONE = 10, B_ERR = 9, B_LDA = 8, B_LDB = 7, B_ABUS = 6;
  localparam int B_ALUBUS = 4, B_SUB = 3, B_LAT = 2, B_EXTBUS = 1, B_EXTCAP = 0;

  typedef struct {
    int          d;
    logic [2:0]  op;
    logic [31:0] ext;
    int          lat;
    logic        err;
    bit          chk_a;
    logic [31:0] a;
    bit          chk_cap;
    logic [31:0] cap;
    bit          chk_fl;
    logic [1:0]  fl;
  } row_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  valid;
  logic [2:0]  cmd_op;
  logic [31:0] ext_val;
  logic [1:0]  rdy, dn, er, lda, ldb, ab, bb, alub, sub, lat, eb, ec, az, an;
  vec_t        act [2];
  logic [31:0] bus [2];
  logic [31:0] rA [2], rB [2], rALU [2], cap [2];

  int          checks, failures;
  int unsigned mcyc;
  int          acc_cnt [2], done_cnt [2];
  vec_t        exp_q [2][64];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_obs
    assign act[g] = {rdy[g], dn[g], er[g], lda[g], ldb[g], ab[g], bb[g], alub[g], sub[g], lat[g], eb[g], ec[g]};
    assign bus[g] = eb[g] ? ext_val : ab[g] ? rA[g] : bb[g] ? rB[g] : alub[g] ? rALU[g] : 32'h0;
  end

  // External datapath model driven by the strobes.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (lda[d]) rA[d] <= bus[d];
      if (ldb[d]) rB[d] <= bus[d];
      if (lat[d]) rALU[d] <= sub[d] ? rA[d] - rB[d] : rA[d] + rB[d];
      if (ec[d])  cap[d] <= bus[d];
    end
  end

  ssem_sequencer #(.SETTLE_CYCLES(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(valid[0]), .cmd_op(cmd_op),
    .cmd_ready(rdy[0]), .done(dn[0]), .cmd_err(er[0]), .load_A(lda[0]), .load_B(ldb[0]),
    .a_to_bus(ab[0]), .b_to_bus(bb[0]), .alu_to_bus(alub[0]), .alu_sub(sub[0]),
    .alu_latch(lat[0]), .ext_to_bus(eb[0]), .ext_capture(ec[0])
`ifdef SSEM_SEQ_FLAGS_EN
    , .bus_in(bus[0]), .acc_zero(az[0]), .acc_neg(an[0])
`endif
  );

  ssem_sequencer #(.SETTLE_CYCLES(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(valid[1]), .cmd_op(cmd_op),
    .cmd_ready(rdy[1]), .done(dn[1]), .cmd_err(er[1]), .load_A(lda[1]), .load_B(ldb[1]),
    .a_to_bus(ab[1]), .b_to_bus(bb[1]), .alu_to_bus(alub[1]), .alu_sub(sub[1]),
    .alu_latch(lat[1]), .ext_to_bus(eb[1]), .ext_capture(ec[1])
`ifdef SSEM_SEQ_FLAGS_EN
    , .bus_in(bus[1]), .acc_zero(az[1]), .acc_neg(an[1])
`endif
  );

`ifndef SSEM_SEQ_FLAGS_EN
  assign az = 2'b00;
  assign an = 2'b00;
`endif

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // Writes the expected output schedule of a command accepted in cycle c.
  task automatic sched(input int d, input logic [2:0] op, input int unsigned c);
    int unsigned s, lt, xs;
    int sb, db;
    s  = (d == 0) ? 1 : 4;
    xs = 0; sb = 0; db = 0; lt = 1;
    case (op)
      3'd1: begin lt = 4; xs = 1; sb = B_EXTBUS; db = B_LDA;    end
      3'd2: begin lt = 4; xs = 1; sb = B_EXTBUS; db = B_LDB;    end
      3'd5: begin lt = 4; xs = 1; sb = B_ABUS;   db = B_EXTCAP; end
      3'd6: begin lt = 4; xs = 1; sb = B_ABUS;   db = B_LDB;    end
      3'd3, 3'd4: begin lt = s + 5; xs = s + 2; sb = B_ALUBUS; db = B_LDA; end
      default: lt = 1;
    endcase
    for (int unsigned k = 1; k < lt; k++) exp_q[d][(c + k) % 64][B_RDY] = 1'b0;
    exp_q[d][(c + lt) % 64][B_DONE] = 1'b1;
    exp_q[d][(c + lt) % 64][B_ERR]  = (op == 3'd7);
    if (op == 3'd3 || op == 3'd4) begin
      for (int unsigned k = 1; k <= s + 4; k++) exp_q[d][(c + k) % 64][B_SUB] = (op == 3'd4);
      exp_q[d][(c + s + 1) % 64][B_LAT] = 1'b1;
    end
    if (xs != 0) begin
      for (int unsigned k = xs; k < xs + 3; k++) exp_q[d][(c + k) % 64][sb] = 1'b1;
      exp_q[d][(c + xs + 1) % 64][db] = 1'b1;
    end
    acc_cnt[d]++;
  endtask

  // Per-cycle comparison against the schedule plus the bus invariants.
  initial begin
    mcyc = 0;
    for (int d = 0; d < 2; d++) begin
      acc_cnt[d] = 0; done_cnt[d] = 0;
      for (int k = 0; k < 64; k++) exp_q[d][k] = IDLE_V;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!reset_n) begin
          for (int k = 0; k < 64; k++) exp_q[d][k] = IDLE_V;
        end else begin
          vec_t e;
          logic ok;
          e = exp_q[d][mcyc % 64];
          chk($sformatf("cycle%0d_dut%0d", mcyc, d), 32'(act[d]), 32'(e));
          ok = ($countones({act[d].a_bus, act[d].b_bus, act[d].alu_bus, act[d].ext_bus}) <= 1) &&
               !(act[d].ld_a && act[d].ld_b) &&
               !(act[d].latch && (act[d].a_bus || act[d].b_bus || act[d].alu_bus || act[d].ext_bus));
          chk($sformatf("invariant%0d_dut%0d", mcyc, d), 32'(ok), 32'd1);
          if (act[d].done) done_cnt[d]++;
          exp_q[d][mcyc % 64] = IDLE_V;
          if (valid[d] && e.ready) sched(d, cmd_op, mcyc);
        end
      end
      mcyc++;
    end
  end

  // Issues one command; returns done latency (-1 on timeout), cmd_err and alu_latch cycle.
  task automatic run_cmd(input int d, input logic [2:0] op, input logic [31:0] ext,
                         output int lt, output logic err, output int latk);
    lt = -1; err = 1'b0; latk = 0;
    cmd_op = op; ext_val = ext; valid[d] = 1'b1;
    @(posedge clk); #1;
    valid[d] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (lat[d] && latk == 0) latk = k;
      if (dn[d]) begin lt = k; err = er[d]; break; end
    end
    @(posedge clk); #1;
  endtask

  row_t tbl [13];
  int   lt_v, latk_v, a0 [2], d0 [2], ncyc, found, dones;
  logic err_v;

  initial begin
    tbl[0]  = '{0, 3'd1, 32'd5, 4, 1'b0, 1'b1, 32'd5,        1'b0, 32'd0, 1'b1, 2'b00};
    tbl[1]  = '{0, 3'd2, 32'd3, 4, 1'b0, 1'b0, 32'd0,        1'b0, 32'd0, 1'b0, 2'b00};
    tbl[2]  = '{0, 3'd3, 32'd0, 6, 1'b0, 1'b1, 32'd8,        1'b0, 32'd0, 1'b1, 2'b00};
    tbl[3]  = '{0, 3'd5, 32'd0, 4, 1'b0, 1'b0, 32'd0,        1'b1, 32'd8, 1'b0, 2'b00};
    tbl[4]  = '{1, 3'd1, 32'd3, 4, 1'b0, 1'b1, 32'd3,        1'b0, 32'd0, 1'b0, 2'b00};
    tbl[5]  = '{1, 3'd2, 32'd5, 4, 1'b0, 1'b0, 32'd0,        1'b0, 32'd0, 1'b0, 2'b00};
    tbl[6]  = '{1, 3'd4, 32'd0, 9, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 32'd0, 1'b1, 2'b01};
    tbl[7]  = '{1, 3'd1, 32'd5, 4, 1'b0, 1'b1, 32'd5,        1'b0, 32'd0, 1'b1, 2'b00};
    tbl[8]  = '{1, 3'd4, 32'd0, 9, 1'b0, 1'b1, 32'd0,        1'b0, 32'd0, 1'b1, 2'b10};
    tbl[9]  = '{0, 3'd7, 32'd0, 1, 1'b1, 1'b0, 32'd0,        1'b0, 32'd0, 1'b0, 2'b00};
    tbl[10] = '{0, 3'd0, 32'd0, 1, 1'b0, 1'b0, 32'd0,        1'b0, 32'd0, 1'b0, 2'b00};
    tbl[11] = '{0, 3'd6, 32'd0, 4, 1'b0, 1'b0, 32'd0,        1'b0, 32'd0, 1'b0, 2'b00};
    tbl[12] = '{0, 3'd4, 32'd0, 6, 1'b0, 1'b1, 32'd0,        1'b0, 32'd0, 1'b1, 2'b10};

    checks = 0; failures = 0;
    valid = 2'b00; cmd_op = 3'd0; ext_val = 32'h0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    chk("reset_dut0", 32'(act[0]), 32'(IDLE_V));
    chk("reset_dut1", 32'(act[1]), 32'(IDLE_V));
    chk("reset_flags", {28'h0, az, an}, 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      int s;
      s = (tbl[i].d == 0) ? 1 : 4;
      run_cmd(tbl[i].d, tbl[i].op, tbl[i].ext, lt_v, err_v, latk_v);
      chk($sformatf("row%0d_done_latency", i), 32'(lt_v), 32'(tbl[i].lat));
      chk($sformatf("row%0d_cmd_err", i), 32'(err_v), 32'(tbl[i].err));
      if (tbl[i].op == 3'd3 || tbl[i].op == 3'd4)
        chk($sformatf("row%0d_latch_cycle", i), 32'(latk_v), 32'(s + 1));
      if (tbl[i].chk_a)
        chk($sformatf("row%0d_regA", i), rA[tbl[i].d], tbl[i].a);
      if (tbl[i].chk_cap)
        chk($sformatf("row%0d_ext_capture", i), cap[tbl[i].d], tbl[i].cap);
`ifdef SSEM_SEQ_FLAGS_EN
      if (tbl[i].chk_fl)
        chk($sformatf("row%0d_flags", i), {30'h0, az[tbl[i].d], an[tbl[i].d]}, {30'h0, tbl[i].fl});
`endif
    end

    // Reset during the STROBE cycle of an ADD.
    cmd_op = 3'd3; valid[0] = 1'b1;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    found = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (lda[0]) begin found = 1; break; end
    end
    chk("midadd_strobe_reached", 32'(found), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("midadd_async_clear", 32'(act[0]), 32'(IDLE_V));
    @(posedge clk); #1;
    @(posedge clk); #1 reset_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (dn[0]) dones++;
    end
    chk("midadd_no_done", 32'(dones), 32'd0);
    chk("midadd_ready_after", 32'(rdy[0]), 32'd1);
    @(posedge clk); #1;

    // Back-to-back random commands with cmd_valid held high.
    for (int d = 0; d < 2; d++) begin a0[d] = acc_cnt[d]; d0[d] = done_cnt[d]; end
    valid = 2'b11;
    ncyc = 0;
    while ((acc_cnt[0] - a0[0]) < 500 && ncyc < 20000) begin
      cmd_op  = 3'($urandom_range(0, 7));
      ext_val = $urandom;
      @(posedge clk); #1;
      ncyc++;
    end
    valid = 2'b00;
    chk("random_ops_issued", 32'((acc_cnt[0] - a0[0]) >= 500), 32'd1);
    repeat (30) @(posedge clk);
    #1;
    chk("accept_eq_done_dut0", 32'(acc_cnt[0] - a0[0]), 32'(done_cnt[0] - d0[0]));
    chk("accept_eq_done_dut1", 32'(acc_cnt[1] - a0[1]), 32'(done_cnt[1] - d0[1]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ssem_sequencer.md
Name: ssem_sequencer

Overview:
- Command-driven micro-sequencer for the SSEM datapath (registers A and B, add/sub ALU, shared 32-bit tristate bus).
- Accepts one operation at a time over a valid/ready handshake.
- Emits registered control strobes: load_A, load_B, a_to_bus, b_to_bus, alu_sub, alu_latch, alu_to_bus, plus ext_to_bus and ext_capture for the external store/switch interface.
- Guarantees at most one bus driver per cycle; sits between instruction decode and the ssem core.

Parameters:
- SETTLE_CYCLES, 1, cycles alu_sub is held before alu_latch pulses (1..15; 0 is illegal).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_op  input  3  opcode: 0 NOP, 1 LDA, 2 LDB, 3 ADD, 4 SUB, 5 STA, 6 MOVAB, 7 illegal
- cmd_ready  output  1  sequencer can accept a command
- done  output  1  one-cycle pulse when the command completes
- cmd_err  output  1  one-cycle pulse, coincident with done, for opcode 7
- load_A, load_B  output  1 each  register latch enables
- a_to_bus, b_to_bus, alu_to_bus  output  1 each  bus output enables
- alu_sub  output  1  ALU mode (0 add, 1 sub)
- alu_latch  output  1  ALU result latch enable
- ext_to_bus  output  1  external source drives bus (store read / switches)
- ext_capture  output  1  external sink latches bus

Behaviour:
- Interface is fixed: one clock clk; reset_n is asynchronous, active-low.
- Reset:
  - All outputs are 0 except cmd_ready = 1.
  - State is IDLE.
  - Reset asserted mid-operation drops all strobes immediately (asynchronous). No completion pulse follows.
- Handshake:
  - Command accepted at T0 when cmd_valid && cmd_ready.
  - cmd_ready = 1 only in IDLE. cmd_op is sampled at T0 only.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Transfer primitive: three cycles, with the source and destination pairs given below.
  - SETUP: source OE = 1.
  - STROBE: source OE = 1, destination LE = 1.
  - HOLD: source OE = 1, destination LE = 0.
  - The source OE is never dropped in the same cycle as the destination LE.
- Opcode sequences (the last transfer cycle is T3 unless stated):
  - LDA: ext_to_bus -> load_A. done and cmd_ready at T4.
  - LDB: ext_to_bus -> load_B. done at T4.
  - STA: a_to_bus -> ext_capture. done at T4.
  - MOVAB: a_to_bus -> load_B. done at T4.
  - ADD/SUB: SETTLE phase T1..T(SETTLE_CYCLES) with alu_sub driven and no bus driver. LATCH cycle pulses alu_latch = 1 for one cycle. Then transfer alu_to_bus -> load_A (3 cycles). done at T(SETTLE_CYCLES+5).
    - alu_sub is held constant from SETTLE through the end of the transfer, and returns to 0 in IDLE.
  - NOP: no strobes; done at T1.
  - Opcode 7: same as NOP, with cmd_err = 1 alongside done.
- State machine: IDLE, SETTLE (counter), LATCH, SETUP, STROBE, HOLD, DONE.
  - DONE is merged with IDLE: done pulses in the cycle the FSM re-enters IDLE.
  - A new command may be accepted in the same cycle done is high.
- Invariants:
  - Per cycle, a_to_bus + b_to_bus + alu_to_bus + ext_to_bus <= 1.
  - load_A and load_B are never both 1.
  - alu_latch is never 1 while any bus OE is 1.
- cmd_valid held high continuously: back-to-back commands with no idle gap beyond the done cycle.

Optional Feature:
- Macro: SSEM_SEQ_FLAGS_EN.
- Defined:
  - Adds input bus_in [31:0] (bus observation) and outputs acc_zero, acc_neg (1 bit each).
  - Both flags are captured from bus_in in the STROBE cycle of any transfer whose destination is A.
  - acc_neg = bus_in[31]; acc_zero = (bus_in == 0).
  - Both flags reset to 0 and are held otherwise.
- Undefined: these ports and their logic are absent, and timing is identical.

Decomposition:
- Package ssem_seq_pkg holds:
  - Opcode enum.
  - FSM state enum.
  - Source/destination select enums: SRC_EXT, SRC_A, SRC_B, SRC_ALU; DST_A, DST_B, DST_EXT.
  - Constant XFER_CYCLES = 3.
- Sub-module ssem_bus_xfer:
  - Inputs: start, src, dst.
  - Outputs: one-hot OE/LE strobes and a finish pulse.
  - Implements the SETUP/STROBE/HOLD engine; the top FSM handles opcode decode, SETTLE and LATCH.

Test Plan:
- Reset mid-ADD (assert reset_n = 0 during the STROBE cycle) -> all strobes 0 asynchronously; cmd_ready = 1 after release; no done pulse.
- LDA with ext driving 32'h00000005, then LDB with 32'h00000003, then ADD (SETTLE_CYCLES = 1), then STA -> ext_capture sees 32'h00000008. Cycle checks:
  - ADD: done at T6.
  - LDA, LDB, STA: done at T4 each.
- LDA 3, LDB 5, SUB -> A = 32'hFFFFFFFE. With SETTLE_CYCLES = 4, alu_latch is high only at T5 and done at T9.
- Opcode 7, then opcode 0 -> done at T1 each; cmd_err only on the first; zero strobes throughout.
- Back-to-back random commands (cmd_valid held 1, 500 ops) -> the bus-driver and load-enable invariants hold on every cycle; accept count equals done count.
- SSEM_SEQ_FLAGS_EN: SUB giving 32'hFFFFFFFE -> acc_neg = 1, acc_zero = 0. A following SUB of equal operands -> acc_zero = 1, acc_neg = 0.
